// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the PC, fetches over imem req/ack, issues to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned branch targets fault and halt instead of being truncated.
module fetch_sequencer #(
  parameter int unsigned N       = 32,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pc_i,
  output logic [1:0]   pc_sel_o,
  output logic [N-1:0] jump_dir_o,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic         imem_ack_i,
  input  logic [W-1:0] imem_data_i,
  output logic [W-1:0] instr_o,
  output logic [N-1:0] instr_pc_o,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  input  logic         branch_i,
  input  logic [N-1:0] branch_target_i,
  output logic         fault_o
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

  typedef enum logic [2:0] {RST, FETCH, ISSUE, DRAIN, HALT} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] instr_q, instr_d;
  logic [N-1:0] instr_pc_q, instr_pc_d;
  logic [N-1:0] drain_addr_q, drain_addr_d;
  logic         fault_q, fault_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   cnt_inc;
  logic         br_active;
  logic         misalign;

  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign br_active = branch_i && (state_q == FETCH || state_q == ISSUE || state_q == DRAIN);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = br_active && (branch_target_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      drain_addr_q <= '0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      drain_addr_q <= drain_addr_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    drain_addr_d = drain_addr_q;
    fault_d      = fault_q;
    cnt_d        = cnt_q;
    pc_sel_o     = 2'b01;
    jump_dir_o   = '0;
    imem_req_o   = 1'b0;
    imem_addr_o  = '0;

    unique case (state_q)
      RST: begin
        pc_sel_o = 2'b00;
        cnt_d    = '0;
        state_d  = FETCH;
      end
      FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_i;
        if (misalign) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (branch_i) begin
          cnt_d = '0;
          if (!imem_ack_i) begin
            drain_addr_d = pc_i;
            state_d      = DRAIN;
          end
        end else if (imem_ack_i) begin
          pc_sel_o   = 2'b10;
          instr_d    = imem_data_i;
          instr_pc_d = pc_i;
          state_d    = ISSUE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TMO) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      ISSUE: begin
        if (misalign) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (branch_i || instr_ready_i) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
        // A branch here only redirects the PC; the counter keeps running and
        // an expiry it crosses is acted on by the next non-branch cycle.
        if (misalign) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (branch_i) begin
          cnt_d = cnt_inc;
        end else if (imem_ack_i) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TMO) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
      end
      default: state_d = RST;
    endcase

    if (br_active && !misalign) begin
      pc_sel_o   = 2'b11;
      jump_dir_o = branch_target_i & ALIGN_MASK;
    end
  end

  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = (state_q == ISSUE);
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand sequences,
// and randomized traffic against a flag-based behavioural model with a PC and memory.
module tb_fetch_sequencer;
  localparam int N   = 32;
  localparam int W   = 32;
  localparam int TMO = 16;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pc_q;
  logic [1:0]   pc_sel;
  logic [N-1:0] jump_dir;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_data;
  logic [W-1:0] instr;
  logic [N-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         branch;
  logic [N-1:0] branch_target;
  logic         fault;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_i            (pc_q),
    .pc_sel_o        (pc_sel),
    .jump_dir_o      (jump_dir),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_data_i     (imem_data),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .fault_o         (fault)
  );

  function automatic logic [W-1:0] mdata(input logic [N-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_data = mdata(imem_addr);

  // Program counter driven by the sequencer's select
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else begin
      case (pc_sel)
        2'b00:   pc_q <= '0;
        2'b01:   pc_q <= pc_q;
        2'b10:   pc_q <= pc_q + 32'd4;
        default: pc_q <= jump_dir;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic br, input logic [N-1:0] tgt);
    imem_ack      = ack;
    instr_ready   = rdy;
    branch        = br;
    branch_target = tgt;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " sel"},   64'(pc_sel), 64'd0);
    chk({tag, " jump"},  64'(jump_dir), 64'd0);
    chk({tag, " req"},   64'(imem_req), 64'd0);
    chk({tag, " addr"},  64'(imem_addr), 64'd0);
    chk({tag, " valid"}, 64'(instr_valid), 64'd0);
    chk({tag, " instr"}, 64'(instr), 64'd0);
    chk({tag, " ipc"},   64'(instr_pc), 64'd0);
    chk({tag, " fault"}, 64'(fault), 64'd0);
  endtask

  // Leaves the bench at a negedge with reset just released (sequencer in its reset state)
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  bit           m_boot, m_dead, m_have, m_drain, m_fault;
  int           m_wait;
  logic [N-1:0] m_daddr, m_ipc;
  logic [W-1:0] m_instr;
  logic [1:0]   e_sel;
  logic         e_req;
  logic [N-1:0] e_addr, e_jump;

  task automatic model_reset();
    m_boot = 1; m_dead = 0; m_have = 0; m_drain = 0; m_fault = 0;
    m_wait = 0; m_daddr = '0; m_ipc = '0; m_instr = '0;
  endtask

  task automatic model_bump();
    m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
    if (m_wait >= TMO) begin
      m_fault = 1; m_dead = 1; m_drain = 0;
    end
  endtask

  task automatic model_step(input logic ack, input logic rdy, input logic br,
                            input logic [N-1:0] tgt, input logic [N-1:0] pc);
    bit fetching, mis, jmp;
    fetching = !m_boot && !m_dead && !m_have && !m_drain;
    mis      = TRAP && br && (tgt[1:0] != 2'b00) && !m_boot && !m_dead;
    jmp      = br && !mis && !m_boot && !m_dead;
    e_sel    = m_boot ? 2'd0 : (jmp ? 2'd3 : 2'd1);
    e_req    = fetching || m_drain;
    e_addr   = m_drain ? m_daddr : pc;
    e_jump   = {tgt[N-1:2], 2'b00};
    if (m_boot) begin
      m_boot = 0; m_wait = 0;
    end else if (m_dead) begin
    end else if (mis) begin
      m_fault = 1; m_dead = 1; m_have = 0; m_drain = 0;
    end else if (fetching) begin
      if (br) begin
        m_wait = 0;
        if (!ack) begin m_drain = 1; m_daddr = pc; end
      end else if (ack) begin
        e_sel = 2'd2; m_instr = mdata(pc); m_ipc = pc; m_have = 1;
      end else model_bump();
    end else if (m_have) begin
      if (br || rdy) begin m_have = 0; m_wait = 0; end
    end else begin
      if (br) m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
      else if (ack) begin m_drain = 0; m_wait = 0; end
      else model_bump();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         ack, rdy, br;
    logic [N-1:0] tgt;
    logic [1:0]   sel;
    logic         req;
    logic [N-1:0] addr;
    logic         valid;
    logic [N-1:0] ipc;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int mem_w, mem_lat, dead_cnt;
    logic         a, r, b;
    logic [N-1:0] t;

    tbl[0]  = '{0, 0, 0, 32'h0,  2'd0, 0, 32'h0,  0, 32'h0};
    tbl[1]  = '{0, 1, 0, 32'h0,  2'd1, 1, 32'h0,  0, 32'h0};
    tbl[2]  = '{0, 1, 0, 32'h0,  2'd1, 1, 32'h0,  0, 32'h0};
    tbl[3]  = '{1, 1, 0, 32'h0,  2'd2, 1, 32'h0,  0, 32'h0};
    tbl[4]  = '{0, 1, 0, 32'h0,  2'd1, 0, 32'h0,  1, 32'h0};
    tbl[5]  = '{0, 1, 0, 32'h0,  2'd1, 1, 32'h4,  0, 32'h0};
    tbl[6]  = '{0, 1, 0, 32'h0,  2'd1, 1, 32'h4,  0, 32'h0};
    tbl[7]  = '{1, 1, 0, 32'h0,  2'd2, 1, 32'h4,  0, 32'h0};
    for (int i = 8; i <= 12; i++)
      tbl[i] = '{0, 0, 0, 32'h0, 2'd1, 0, 32'h0, 1, 32'h4};
    tbl[13] = '{0, 1, 1, 32'h40, 2'd3, 0, 32'h0,  1, 32'h4};
    tbl[14] = '{0, 1, 1, 32'h80, 2'd3, 1, 32'h40, 0, 32'h4};
    tbl[15] = '{0, 1, 0, 32'h0,  2'd1, 1, 32'h40, 0, 32'h4};
    tbl[16] = '{1, 1, 0, 32'h0,  2'd1, 1, 32'h40, 0, 32'h4};
    tbl[17] = '{1, 1, 0, 32'h0,  2'd2, 1, 32'h80, 0, 32'h4};
    tbl[18] = '{0, 1, 0, 32'h0,  2'd1, 0, 32'h0,  1, 32'h80};
    tbl[19] = '{0, 1, 0, 32'h0,  2'd1, 1, 32'h84, 0, 32'h80};

    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].ack, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
      #1;
      chk($sformatf("vec%0d sel", i),   64'(pc_sel), 64'(tbl[i].sel));
      chk($sformatf("vec%0d req", i),   64'(imem_req), 64'(tbl[i].req));
      chk($sformatf("vec%0d valid", i), 64'(instr_valid), 64'(tbl[i].valid));
      chk($sformatf("vec%0d ipc", i),   64'(instr_pc), 64'(tbl[i].ipc));
      if (tbl[i].req)   chk($sformatf("vec%0d addr", i), 64'(imem_addr), 64'(tbl[i].addr));
      if (tbl[i].sel == 2'd3)
        chk($sformatf("vec%0d jump", i), 64'(jump_dir), 64'(tbl[i].tgt & ~32'h3));
      if (tbl[i].valid) chk($sformatf("vec%0d instr", i), 64'(instr), 64'(mdata(tbl[i].ipc)));
      @(negedge clk);
    end

    // ---------------- timeout, halt and restart ----------------
    do_reset();
    #1 chk("tmo rst sel", 64'(pc_sel), 64'd0);
    @(negedge clk);
    for (int k = 1; k <= TMO; k++) begin
      #1;
      chk($sformatf("tmo wait%0d req", k), 64'(imem_req), 64'd1);
      chk($sformatf("tmo wait%0d fault", k), 64'(fault), 64'd0);
      @(negedge clk);
    end
    #1;
    chk("tmo fault", 64'(fault), 64'd1);
    chk("tmo req", 64'(imem_req), 64'd0);
    chk("tmo valid", 64'(instr_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h100);
      #1;
      chk("halt sel", 64'(pc_sel), 64'd1);
      chk("halt fault", 64'(fault), 64'd1);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1 check_reset_outputs("halt reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("restart sel", 64'(pc_sel), 64'd0);
    @(negedge clk);
    #1;
    chk("restart req", 64'(imem_req), 64'd1);
    chk("restart addr", 64'(imem_addr), 64'd0);

    // ---------------- misaligned branch target ----------------
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h42);
    #1;
    if (TRAP) chk("mis sel", 64'(pc_sel), 64'd1);
    else begin
      chk("mis sel", 64'(pc_sel), 64'd3);
      chk("mis jump", 64'(jump_dir), 64'h40);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("mis valid", 64'(instr_valid), 64'd0);
    if (TRAP) begin
      chk("mis fault", 64'(fault), 64'd1);
      chk("mis req", 64'(imem_req), 64'd0);
      chk("mis halt sel", 64'(pc_sel), 64'd1);
    end else begin
      chk("mis fault", 64'(fault), 64'd0);
      chk("mis req", 64'(imem_req), 64'd1);
      chk("mis addr", 64'(imem_addr), 64'h40);
    end

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    model_reset();
    mem_w = 0; mem_lat = 1; dead_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ((m_dead && dead_cnt >= 4) || $urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        #1 check_reset_outputs("rnd reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mem_w = 0; dead_cnt = 0;
      end
      r = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 5) == 0);
      t = $urandom & ~32'h3;
      if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if (imem_req) begin
        if (mem_w >= mem_lat) begin
          a = 1'b1; mem_w = 0;
          mem_lat = ($urandom_range(0, 39) == 0) ? 40 : $urandom_range(0, 3);
        end else begin
          a = 1'b0; mem_w++;
        end
      end else begin
        a = 1'b0; mem_w = 0;
      end
      drive(a, r, b, t);
      #1;
      chk("rnd valid", 64'(instr_valid), 64'(m_have));
      chk("rnd fault", 64'(fault), 64'(m_fault));
      chk("rnd ipc",   64'(instr_pc), 64'(m_ipc));
      chk("rnd instr", 64'(instr), 64'(m_instr));
      model_step(a, r, b, t, pc_q);
      chk("rnd sel", 64'(pc_sel), 64'(e_sel));
      chk("rnd req", 64'(imem_req), 64'(e_req));
      if (e_req) chk("rnd addr", 64'(imem_addr), 64'(e_addr));
      if (e_sel == 2'd3) chk("rnd jump", 64'(jump_dir), 64'(e_jump));
      dead_cnt = m_dead ? dead_cnt + 1 : 0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
